// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the RV32M mul/div unit.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface rv32m_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] value1;
   logic [XLEN-1:0] value2;
   logic            flush;
   logic            busy;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out;

   // Pipeline side: issues operations, kills them, consumes results
   modport master (
      output in_valid, funct3, value1, value2, flush, out_ready,
      input  in_ready, busy, out_valid, out
   );

   // Unit side
   modport slave (
      input  in_valid, funct3, value1, value2, flush, out_ready,
      output in_ready, busy, out_valid, out
   );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring-divide step per cycle.
// Latency: out_valid rises XLEN+2 edges after accept; divide-by-zero/overflow after 1 edge.
// Backpressure: accepts only in IDLE; result held in DONE until out_ready; flush aborts anything.
module rv32m_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   rv32m_muldiv_unit_if.slave  io
);
   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;      // product / quotient must be negated
   logic                rsgn_q, rsgn_d;    // remainder takes the dividend sign
   logic [XLEN-1:0]     mcand_q, mcand_d;  // |rs2|: multiplicand or divisor
   logic [2*XLEN-1:0]   acc_q, acc_d;      // mul: {hi, multiplier}; div: {remainder, dividend/quotient}
   logic [XLEN-1:0]     out_q, out_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;
   logic                out_valid_q, out_valid_d;

   logic                sgn1, sgn2, s1, s2;
   logic [XLEN-1:0]     mag1, mag2;
   logic                div_zero, div_ovf, accept;
   logic [XLEN:0]       mul_add, trial, diff;
   logic [2*XLEN-1:0]   mul_next, div_next, prod;
   logic [XLEN-1:0]     quo, rem, res;

   // Operand decode at accept, one iteration step, and sign fix-up of the finished result
   always_comb begin
      sgn1     = (io.funct3 == 3'd0) || (io.funct3 == 3'd1) || (io.funct3 == 3'd2)
              || (io.funct3 == 3'd4) || (io.funct3 == 3'd6);
      sgn2     = (io.funct3 == 3'd0) || (io.funct3 == 3'd1)
              || (io.funct3 == 3'd4) || (io.funct3 == 3'd6);
      s1       = sgn1 & io.value1[XLEN-1];
      s2       = sgn2 & io.value2[XLEN-1];
      mag1     = s1 ? -io.value1 : io.value1;
      mag2     = s2 ? -io.value2 : io.value2;
      div_zero = io.funct3[2] && (io.value2 == '0);
      div_ovf  = ((io.funct3 == 3'd4) || (io.funct3 == 3'd6))
              && (io.value1 == {1'b1, {(XLEN-1){1'b0}}}) && (io.value2 == '1);

      // Shift-add: conditionally add the multiplicand to the high half, then shift right with carry
      mul_add  = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q})
                          : {1'b0, acc_q[2*XLEN-1:XLEN]};
      mul_next = {mul_add, acc_q[XLEN-1:1]};

      // Restoring divide: shift in the next dividend bit, keep the difference if it did not borrow
      trial    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff     = trial - {1'b0, mcand_q};
      div_next = diff[XLEN] ? {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

      prod     = neg_q  ? -acc_q : acc_q;
      quo      = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem      = rsgn_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (op_q[2])
         res = op_q[1] ? rem : quo;
      else
         res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   // Next-state, datapath register and registered-output computation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      rsgn_d  = rsgn_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      out_d   = out_q;
      accept  = io.in_valid && in_ready_q && !io.flush;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = io.funct3;
               neg_d   = s1 ^ s2;
               rsgn_d  = s1;
               mcand_d = mag2;
               acc_d   = {{XLEN{1'b0}}, mag1};
               cnt_d   = '0;
               if (div_zero) begin
                  out_d   = io.funct3[1] ? io.value1 : '1;
                  state_d = DONE;
               end else if (div_ovf) begin
                  out_d   = io.funct3[1] ? '0 : io.value1;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = op_q[2] ? div_next : mul_next;
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               cnt_d   = '0;
               state_d = FIXUP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FIXUP: begin
            out_d   = res;
            state_d = DONE;
         end
         DONE: begin
            if (out_valid_q && io.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A kill overrides everything, including a same-cycle accept or result handshake
      if (io.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         out_d   = out_q;
      end

      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d == CALC) || (state_d == FIXUP);
      // out_valid trails DONE entry by one cycle, so the result register is settled before it is offered
      out_valid_d = (state_q == DONE) && (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         rsgn_q      <= 1'b0;
         mcand_q     <= '0;
         acc_q       <= '0;
         out_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         rsgn_q      <= rsgn_d;
         mcand_q     <= mcand_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign io.in_ready  = in_ready_q;
   assign io.busy      = busy_q;
   assign io.out_valid = out_valid_q;
   assign io.out       = out_q;
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed and randomized checks of rv32m_muldiv_unit against an arithmetic reference model.
// Latency: checks XLEN+2 / 1 edge result timing from the accept edge.
// Backpressure: exercises held results, flush kill and mid-operation reset.
module tb_rv32m_muldiv_unit;
   localparam int XLEN = 32;
   localparam int NLAT = XLEN + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rv32m_muldiv_unit_if #(.XLEN(XLEN)) bus ();

   rv32m_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   // RV32M results from plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub;
      logic [63:0] p;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 0) || (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.funct3   = f;
      bus.value1   = a;
      bus.value2   = b;
      tick();
      // scramble inputs: only the accept-edge values may matter
      bus.in_valid = 1'b0;
      bus.funct3   = 3'($urandom);
      bus.value1   = $urandom;
      bus.value2   = $urandom;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int n;
      bit sp;
      sp = is_special(f, a, b);
      issue(f, a, b);
      chk({tag, "/in_ready_busy"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "/busy"}, 64'(bus.busy), sp ? 64'd0 : 64'd1);
      wait_valid(n);
      chk({tag, "/latency"}, 64'(n), sp ? 64'd1 : 64'(NLAT));
      chk({tag, "/result"}, 64'(bus.out), 64'(exp));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "/valid_drop"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "/ready_back"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      int n;
      bit seen;
      logic [2:0]  f;
      logic [31:0] a, b;

      bus.in_valid  = 1'b0;
      bus.funct3    = 3'd0;
      bus.value1    = '0;
      bus.value2    = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // reset state
      #12;
      chk("rst/in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst/busy", 64'(bus.busy), 64'd0);
      chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst/out", 64'(bus.out), 64'd0);
      #3 rst_n = 1'b1;
      tick();

      // directed arithmetic and timing
      run_op("MUL",      3'd0, 32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_op("MULH",     3'd1, 32'h8000_0000,   32'h8000_0000, 32'h4000_0000);
      run_op("MULHU",    3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("MULHSU",   3'd2, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("DIV",      3'd4, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD);
      run_op("REM",      3'd6, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF);
      run_op("DIVU",     3'd5, 32'd100,         32'd7,         32'd14);
      run_op("REMU",     3'd7, 32'd100,         32'd7,         32'd2);
      run_op("DIVU0",    3'd5, 32'd5,           32'd0,         32'hFFFF_FFFF);
      run_op("REM0",     3'd6, 32'd5,           32'd0,         32'd5);
      run_op("DIVOVF",   3'd4, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000);
      run_op("REMOVF",   3'd6, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0);

      // result held under backpressure, then back-to-back accept
      issue(3'd5, 32'd100, 32'd7);
      wait_valid(n);
      chk("hold/latency", 64'(n), 64'(NLAT));
      for (int i = 0; i < 10; i++) begin
         chk("hold/out_valid", 64'(bus.out_valid), 64'd1);
         chk("hold/out", 64'(bus.out), 64'd14);
         chk("hold/in_ready", 64'(bus.in_ready), 64'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("hold/release_in_ready", 64'(bus.in_ready), 64'd1);
      chk("hold/release_valid", 64'(bus.out_valid), 64'd0);
      a = $urandom; b = $urandom;
      run_op("b2b_MULHU", 3'd3, a, b, model(3'd3, a, b));

      // flush at counter 5, competing with a new request in the same cycle
      issue(3'd1, $urandom, $urandom);
      repeat (5) tick();
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush/in_ready", 64'(bus.in_ready), 64'd1);
      chk("flush/busy", 64'(bus.busy), 64'd0);
      chk("flush/out_valid", 64'(bus.out_valid), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      chk("flush/no_result", 64'(seen), 64'd0);
      chk("flush/still_idle", 64'(bus.in_ready), 64'd1);

      // asynchronous reset at counter 10
      issue(3'd4, $urandom, 32'd3);
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst/in_ready", 64'(bus.in_ready), 64'd1);
      chk("arst/busy", 64'(bus.busy), 64'd0);
      chk("arst/out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst/out", 64'(bus.out), 64'd0);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      chk("arst/no_result", 64'(seen), 64'd0);
      run_op("DIV9_3", 3'd4, 32'd9, 32'd3, 32'd3);

      // randomized operations, biased towards the divide corner cases
      for (int k = 0; k < 40; k++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       b = $urandom_range(1, 15);
            3:       begin a = $urandom_range(0, 255); b = $urandom; end
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d_f%0d", k, f), f, a, b, model(f, a, b));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
